// File: rtl/tick_bcd_pkg.sv
// Shared types and constants for the tick-driven BCD counter.
package tick_bcd_pkg;

  // Counter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  // Largest value a single decade holds before rolling over.
  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage : tick_bcd_pkg

// File: rtl/bcd_digit.sv
// One BCD decade: counts 0..9 on inc, rolls to 0 and raises a
// combinational carry when incremented from 9.
module bcd_digit
  import tick_bcd_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  // Next digit value: clear wins, otherwise increment with rollover at 9.
  always_comb begin
    digit_d = digit_q;
    if (clear) begin
      digit_d = 4'd0;
    end else if (inc) begin
      digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
    end
  end

  // Digit register with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign carry = inc & (digit_q == BCD_MAX);

endmodule : bcd_digit

// File: rtl/tick_bcd_counter.sv
// Multi-decade BCD counter advanced by rising edges of an upstream
// divided-clock level, under control of a three-state IDLE/RUN/PAUSE FSM.
module tick_bcd_counter
  import tick_bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4  // legal range 1..8
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    clk_div,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    running,
  output logic                    wrap,
  output state_e                  state_dbg
);

  // start/stop/clear are single-cycle pulses sampled on the rising edge of
  // clk_in; there is no handshake, a pulse is acted on in the cycle it is
  // high. Priority is clear > stop > start.

  state_e state_q;
  state_e state_d;
  logic   clk_div_q;
  logic   armed_q;
  logic   tick;
  logic   count_en;
  logic   top_carry;
  logic   wrap_q;

  // Edge detector registers; armed_q blanks detection on the first edge
  // after reset so a level already high at release is not seen immediately.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      clk_div_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      clk_div_q <= clk_div;
      armed_q   <= 1'b1;
    end
  end

  assign tick = clk_div & ~clk_div_q & armed_q;

  // FSM state register.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; commands that make no sense in a state are ignored.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (stop)  state_d = PAUSE;
        PAUSE:   if (start) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: run indicator and the count enable for the decade chain.
  // A tick coincident with start is not counted because state_q is not RUN yet.
  always_comb begin
    running  = (state_q == RUN);
    count_en = (state_q == RUN) & tick & ~clear & ~stop;
  end

  // Decade chain: each digit increments on the carry of the one below.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic inc_l;
    logic carry_l;
    if (i == 0) begin : g_lsd
      assign inc_l = count_en;
    end else begin : g_chain
      assign inc_l = g_digit[i-1].carry_l;
    end
    bcd_digit u_digit (
      .clk_in (clk_in),
      .reset  (reset),
      .clear  (clear),
      .inc    (inc_l),
      .digit  (bcd[4*i +: 4]),
      .carry  (carry_l)
    );
  end

  assign top_carry = g_digit[NUM_DIGITS-1].carry_l;

  // Wrap pulse: registered carry out of the most significant decade.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= top_carry;
    end
  end

  assign wrap      = wrap_q;
  assign state_dbg = state_q;

endmodule : tick_bcd_counter

// File: tb/tb_tick_bcd_counter.sv
// Bench for tick_bcd_counter: integer reference model, expected-output
// queue, directed scenarios followed by a random command phase.
module tb_tick_bcd_counter;
  import tick_bcd_pkg::*;

  localparam int N  = 4;
  localparam int BW = 4 * N;
  localparam int EW = BW + 4;

  // ---------------- clock / reset ----------------
  logic          clk_in  = 1'b0;
  logic          reset   = 1'b0;
  logic          clk_div = 1'b0;
  logic          start   = 1'b0;
  logic          stop    = 1'b0;
  logic          clear   = 1'b0;
  logic [BW-1:0] bcd;
  logic          running;
  logic          wrap;
  state_e        state_dbg;

  always #5 clk_in = ~clk_in;

  tick_bcd_counter #(.NUM_DIGITS(N)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .clk_div   (clk_div),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .bcd       (bcd),
    .running   (running),
    .wrap      (wrap),
    .state_dbg (state_dbg)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];  // {state[1:0], running, wrap, bcd}
  int n_checks = 0;
  int n_fail   = 0;

  state_e m_state;
  int     m_count;
  logic   m_divq;
  logic   m_arm;

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] r = '0;
    int x = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = IDLE;
    m_count = 0;
    m_divq  = 1'b0;
    m_arm   = 1'b0;
  endtask

  // Drive one cycle of inputs (called just after a falling edge), predict
  // the post-edge outputs, then compare them on the next falling edge.
  task automatic step(input logic st, input logic sp, input logic cl, input logic dv);
    logic          tk, inc, w;
    int            nc;
    state_e        ns;
    logic [EW-1:0] e;
    start = st; stop = sp; clear = cl; clk_div = dv;
    tk  = dv & ~m_divq & m_arm;
    inc = (m_state == RUN) && tk && !cl && !sp;
    nc  = cl ? 0 : (inc ? (m_count + 1) % pow10(N) : m_count);
    w   = !cl && inc && (m_count == pow10(N) - 1);
    ns  = m_state;
    if (cl) ns = IDLE;
    else if (m_state == IDLE  && st) ns = RUN;
    else if (m_state == RUN   && sp) ns = PAUSE;
    else if (m_state == PAUSE && st) ns = RUN;
    exp_q.push_back({ns, (ns == RUN), w, to_bcd(nc)});
    m_state = ns; m_count = nc; m_divq = dv; m_arm = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    e = exp_q.pop_front();
    check_eq("bcd",     32'(bcd),       32'(e[BW-1:0]));
    check_eq("wrap",    32'(wrap),      32'(e[BW]));
    check_eq("running", 32'(running),   32'(e[BW+1]));
    check_eq("state",   32'(state_dbg), 32'(e[BW+3:BW+2]));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // n rising edges of clk_div: high one cycle, low for gap cycles (0 = random 1..3).
  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      idle_cycles(gap == 0 ? int'($urandom_range(1, 3)) : gap);
    end
  endtask

  task automatic do_reset(input logic div_level);
    reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; clk_div = div_level;
    repeat (3) @(negedge clk_in);
    check_eq("rst_bcd",     32'(bcd),       32'h0);
    check_eq("rst_running", 32'(running),   32'h0);
    check_eq("rst_wrap",    32'(wrap),      32'h0);
    check_eq("rst_state",   32'(state_dbg), 32'(IDLE));
    reset = 1'b1;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    do_reset(1'b0);

    // Start with coincident clk_div rise (not counted), then 12 ticks.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    idle_cycles(1);
    check_eq("start_tick_ignored", 32'(bcd), 32'h0);
    ticks(12, 0);
    check_eq("twelve_bcd",     32'(bcd),     32'h0012);
    check_eq("twelve_running", 32'(running), 32'h1);

    // Rollover from all nines.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(9998, 1);
    check_eq("preload_9998", 32'(bcd), 32'h9998);
    ticks(1, 1);
    check_eq("at_9999", 32'(bcd), 32'h9999);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("wrap_bcd",  32'(bcd),  32'h0000);
    check_eq("wrap_high", 32'(wrap), 32'h1);
    idle_cycles(1);
    check_eq("wrap_one_cycle",   32'(wrap),    32'h0);
    check_eq("wrap_still_run",   32'(running), 32'h1);

    // Pause holds count across ticks, resume continues.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(5, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(3, 0);
    check_eq("pause_hold",    32'(bcd),     32'h0005);
    check_eq("pause_running", 32'(running), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(1, 1);
    check_eq("resume_bcd", 32'(bcd), 32'h0006);

    // Clear with coincident tick.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(41, 1);
    check_eq("at_41", 32'(bcd), 32'h0041);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("clr_tick_bcd",   32'(bcd),       32'h0);
    check_eq("clr_tick_state", 32'(state_dbg), 32'(IDLE));
    check_eq("clr_tick_wrap",  32'(wrap),      32'h0);
    idle_cycles(1);

    // Command priority.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(3, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("all_cmd_state", 32'(state_dbg), 32'(IDLE));
    check_eq("all_cmd_bcd",   32'(bcd),       32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("stop_start_state", 32'(state_dbg), 32'(PAUSE));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("stop_in_pause", 32'(state_dbg), 32'(PAUSE));

    // Asynchronous reset mid-count.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(237, 1);
    check_eq("at_237", 32'(bcd), 32'h0237);
    #2 reset = 1'b0;
    #1;
    check_eq("async_rst_bcd",     32'(bcd),     32'h0);
    check_eq("async_rst_running", 32'(running), 32'h0);
    do_reset(1'b1);

    // clk_div already high at release, then random commands and ticks.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    idle_cycles(2);
    check_eq("high_at_release", 32'(bcd), 32'h0);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tick_bcd_counter
